// File: rtl/divider_if.sv
// Request/result bundle for the 32-bit unsigned divider.
// The master drives the operands and start; the slave returns the status and results.
interface divider_if;
    localparam int unsigned DATA_W = 32;

    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] quot;
    logic [DATA_W-1:0] rem;
    logic              div_zero;

    modport master (
        output start, a, b,
        input  busy, done, quot, rem, div_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, quot, rem, div_zero
    );
endinterface

// File: rtl/divider.sv
// Sequential radix-2 restoring divider: 32 unsigned bits, one quotient bit per cycle.
// Defining DIVIDER_EARLY_OUT_EN finishes a divide-by-zero or a < b in one cycle.
module divider (
    input  logic      clk,
    input  logic      rst_n,
    divider_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] divisor_q, divisor_d;
    logic [DATA_W-1:0] prem_q, prem_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] quot_q, quot_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              div_zero_q, div_zero_d;

    // One restoring step: the partial remainder is 33 bits wide before the trial subtract.
    logic [DATA_W:0]   shifted_c;
    logic [DATA_W:0]   diff_c;
    logic              ge_c;
    logic [DATA_W-1:0] q_step_c;
    logic [DATA_W-1:0] r_step_c;
    logic              early_c;

    assign shifted_c = {prem_q, dvd_q[DATA_W-1]};
    assign ge_c      = (shifted_c >= {1'b0, divisor_q});
    assign diff_c    = shifted_c - {1'b0, divisor_q};
    assign q_step_c  = {dvd_q[DATA_W-2:0], ge_c};
    assign r_step_c  = DATA_W'(ge_c ? diff_c : shifted_c);

`ifdef DIVIDER_EARLY_OUT_EN
    assign early_c = (divisor_q == '0) || (dvd_q < divisor_q);
`else
    assign early_c = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            divisor_q  <= '0;
            prem_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            divisor_q  <= divisor_d;
            prem_q     <= prem_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            div_zero_q <= div_zero_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        divisor_d  = divisor_q;
        prem_d     = prem_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        quot_d     = quot_q;
        rem_d      = rem_q;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = CALC;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    dvd_d     = bus.a;
                    divisor_d = bus.b;
                    prem_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if ((cnt_q == '0) && early_c) begin
                    state_d    = DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    quot_d     = (divisor_q == '0) ? '1 : '0;
                    rem_d      = dvd_q;
                    div_zero_d = (divisor_q == '0);
                end else begin
                    dvd_d  = q_step_c;
                    prem_d = r_step_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        // A zero divisor naturally yields all-ones quotient and rem == a.
                        state_d    = DONE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        quot_d     = q_step_c;
                        rem_d      = r_step_c;
                        div_zero_d = (divisor_q == '0);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.quot     = quot_q;
    assign bus.rem      = rem_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for the sequential divider.
// Expected latencies follow DIVIDER_EARLY_OUT_EN when it is defined.
module tb_divider;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   lat_short;

    divider_if dif ();

    divider u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to the next rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge (T0), then scramble the operands.
    task automatic go(input logic [31:0] a, input logic [31:0] b);
        dif.start = 1'b1;
        dif.a     = a;
        dif.b     = b;
        step();
        dif.start = 1'b0;
        dif.a     = $urandom;
        dif.b     = $urandom;
    endtask

    // Count edges after T0 until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (dif.done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] q, input logic [31:0] r,
                       input logic dz);
        int n;
        go(a, b);
        check({tag, "_busy_t0"}, 32'(dif.busy), 32'd1);
        wait_done(n);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_quot"}, dif.quot, q);
        check({tag, "_rem"}, dif.rem, r);
        check({tag, "_dz"}, 32'(dif.div_zero), 32'(dz));
        check({tag, "_busy_dn"}, 32'(dif.busy), 32'd0);
        step();
        check({tag, "_pulse"}, 32'(dif.done), 32'd0);
        check({tag, "_hold"}, dif.quot, q);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
`ifdef DIVIDER_EARLY_OUT_EN
        lat_short = 1;
`else
        lat_short = 32;
`endif
        rst_n     = 1'b0;
        dif.start = 1'b0;
        dif.a     = '0;
        dif.b     = '0;
        #12;
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_done", 32'(dif.done), 32'd0);
        check("rst_quot", dif.quot, 32'd0);
        check("rst_rem",  dif.rem,  32'd0);
        check("rst_dz",   32'(dif.div_zero), 32'd0);
        rst_n = 1'b1;
        step();

        run("d100_7",  32'd100,       32'd7,          32, 32'd14,        32'd2, 1'b0);
        run("max_1",   32'hFFFFFFFF,  32'd1,          32, 32'hFFFFFFFF,  32'd0, 1'b0);
        run("max_max", 32'hFFFFFFFF,  32'hFFFFFFFF,   32, 32'd1,         32'd0, 1'b0);
        run("d5_0",    32'd5,         32'd0,   lat_short, 32'hFFFFFFFF,  32'd5, 1'b1);
        run("d3_10",   32'd3,         32'd10,  lat_short, 32'd0,         32'd3, 1'b0);
        run("d1000_3", 32'd1000,      32'd3,          32, 32'd333,       32'd1, 1'b0);

        // Start during CALC is ignored; start on the done cycle is a new T0.
        go(32'd100, 32'd7);
        cyc = 0;
        while (dif.done !== 1'b1 && cyc < 100) begin
            if (cyc == 10) begin
                dif.start = 1'b1;
                dif.a     = 32'd9;
                dif.b     = 32'd3;
            end
            step();
            dif.start = 1'b0;
            cyc++;
        end
        check("ign_lat",  32'(cyc), 32'd32);
        check("ign_quot", dif.quot, 32'd14);
        check("ign_rem",  dif.rem,  32'd2);
        go(32'd9, 32'd3);
        check("b2b_busy", 32'(dif.busy), 32'd1);
        check("b2b_done", 32'(dif.done), 32'd0);
        wait_done(cyc);
        check("b2b_lat",  32'(cyc), 32'd32);
        check("b2b_quot", dif.quot, 32'd3);
        check("b2b_rem",  dif.rem,  32'd0);
        step();

        // Reset mid-CALC aborts with no done pulse.
        go(32'd100, 32'd7);
        repeat (14) step();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(dif.busy), 32'd0);
        check("ar_done", 32'(dif.done), 32'd0);
        check("ar_quot", dif.quot, 32'd0);
        check("ar_rem",  dif.rem,  32'd0);
        check("ar_dz",   32'(dif.div_zero), 32'd0);
        step();
        rst_n = 1'b1;
        cyc = 0;
        repeat (40) begin
            step();
            if (dif.done === 1'b1 || dif.busy === 1'b1) cyc++;
        end
        check("ar_quiet", 32'(cyc), 32'd0);
        run("d1000_10", 32'd1000, 32'd10, 32, 32'd100, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have this port: clk  input  1  rising-edge clock, the single clock domain.
REQ-002 The block SHALL have this port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 The block SHALL have this port: start  input  1  request; sampled on clk.
REQ-004 The block SHALL have this port: a  input  32  unsigned dividend.
REQ-005 The block SHALL have this port: b  input  32  unsigned divisor.
REQ-006 The block SHALL have this port: busy  output  1  high while a division is in progress.
REQ-007 The block SHALL have this port: done  output  1  one-cycle pulse when quot/rem become valid.
REQ-008 The block SHALL have this port: quot  output  32  unsigned quotient.
REQ-009 The block SHALL have this port: rem  output  32  unsigned remainder.
REQ-010 The block SHALL have this port: div_zero  output  1  last accepted divisor was zero.
REQ-011 The block SHALL use one clock, clk, and reset rst_n, which is asynchronous and active-low.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-013 In IDLE or DONE, start=1 at a rising edge T0 SHALL latch a and b and enter CALC; busy=1 from T0.
REQ-014 Operand changes on a and b after T0 SHALL NOT affect the result.
REQ-015 CALC SHALL perform radix-2 restoring division: one quotient bit per edge, MSB first, 32 iterations at edges T1..T32.
REQ-016 The block SHALL use a 33-bit partial remainder internally, so no overflow occurs for any 32-bit operands.
REQ-017 At edge T32 the block SHALL enter DONE, drop busy, pulse done for exactly one cycle, and update quot, rem and div_zero.
REQ-018 Latency from the start edge to done-high SHALL be 32 cycles.
REQ-019 quot, rem and div_zero SHALL hold their values until the next completion or reset.
REQ-020 For b!=0, the result SHALL satisfy quot*b+rem==a and rem<b.
REQ-021 For b==0, the block SHALL give quot=32'hFFFFFFFF, rem=a and div_zero=1, with normal latency unless REQ-027 applies.
REQ-022 start while in CALC SHALL be ignored, with no restart and no operand relatch.
REQ-023 start during the done cycle (DONE state) SHALL be accepted as a new T0.
REQ-024 DONE SHALL return to IDLE on the next edge when start=0.

Reset
REQ-025 While rst_n=0, all outputs SHALL be 0 (busy, done, quot, rem, div_zero) and the state SHALL be IDLE.
REQ-026 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after rst_n rises, the block SHALL need a fresh start.

Configuration
REQ-027 With macro DIVIDER_EARLY_OUT_EN defined, a start with b==0 or a<b SHALL skip CALC: at T1 done pulses, busy drops, and results follow REQ-021 (b==0) or are quot=0, rem=a (a<b).
REQ-028 With DIVIDER_EARLY_OUT_EN defined, all other operands SHALL use the full 32-cycle path.
REQ-029 Without DIVIDER_EARLY_OUT_EN, every division SHALL take 32 cycles, with identical results.

Verification
REQ-030 The bench SHALL cover: a=100, b=7, start 1 cycle -> done exactly 32 cycles later, quot=14, rem=2, div_zero=0.
REQ-031 The bench SHALL cover: a=32'hFFFFFFFF, b=1 -> quot=32'hFFFFFFFF, rem=0; then a=32'hFFFFFFFF, b=32'hFFFFFFFF -> quot=1, rem=0.
REQ-032 The bench SHALL cover: a=5, b=0 -> quot=32'hFFFFFFFF, rem=5, div_zero=1; latency is 32 cycles without the macro and 1 cycle with it.
REQ-033 The bench SHALL cover: a=3, b=10 -> quot=0, rem=3; latency is 32 cycles without DIVIDER_EARLY_OUT_EN and 1 cycle with it.
REQ-034 The bench SHALL cover: start a=100, b=7; then at cycle 10 pulse start with a=9, b=3 -> ignored, result is 14/2; then start on the done cycle with a=9, b=3 -> second result 3/0 after 32 more cycles.
REQ-035 The bench SHALL cover: start, then rst_n=0 at cycle 15 -> outputs 0 immediately, no done pulse; after release, 1000/10 -> quot=100, rem=0.
